// File: rtl/itrx_aib_phy_dly_line.sv
// rtl/itrx_aib_phy_dly_line.sv - programmable-depth retiming delay line with settle/lock supervision
// Optional: define ITRX_AIB_PHY_DLY_NEGEDGE_EN for the half-cycle negedge output stage.
module itrx_aib_phy_dly_line #(
    parameter int               WIDTH     = 8,
    parameter int               MAX_DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
    localparam int              SEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic [SEL_W-1:0] dly_sel,
`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
    input  logic             half_sel,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             locked,
    output logic             sel_err
);

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);

    logic [WIDTH-1:0] stg_data_q [1:MAX_DEPTH];
    logic [WIDTH-1:0] stg_data_d [1:MAX_DEPTH];
    logic             stg_vld_q  [1:MAX_DEPTH];
    logic             stg_vld_d  [1:MAX_DEPTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_q_vld, dout_d_vld;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W:0]   settle_q, settle_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;
    logic             sel_oob;
    logic [SEL_W-1:0] sel_c;

    // Clamp out-of-range requests to the deepest implemented tap
    always_comb begin
        sel_oob = (dly_sel > MAX_SEL);
        sel_c   = sel_oob ? MAX_SEL : dly_sel;
    end

    // Select the tap feeding the output register; tap 0 is the raw input word
    always_comb begin
        tap_data = din;
        tap_vld  = din_vld;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (sel_q == SEL_W'(k)) begin
                tap_data = stg_data_q[k];
                tap_vld  = stg_vld_q[k];
            end
        end
    end

    // Next state: shift stages, load output, track selection and settle countdown
    always_comb begin
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            stg_data_d[k] = stg_data_q[k];
            stg_vld_d[k]  = stg_vld_q[k];
        end
        dout_d     = dout_q;
        dout_d_vld = dout_q_vld;
        sel_d      = sel_q;
        settle_d   = settle_q;
        sel_err_d  = sel_err_q | sel_oob;
        if (en) begin
            stg_data_d[1] = din;
            stg_vld_d[1]  = din_vld;
            for (int k = 2; k <= MAX_DEPTH; k++) begin
                stg_data_d[k] = stg_data_q[k-1];
                stg_vld_d[k]  = stg_vld_q[k-1];
            end
            // Old selection drives the output on the cycle the selection changes
            dout_d     = tap_data;
            dout_d_vld = tap_vld;
            if (sel_c != sel_q) begin
                sel_d    = sel_c;
                settle_d = (SEL_W+1)'(sel_c) + 1'b1;
            end else if (settle_q != '0) begin
                settle_d = settle_q - 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                stg_data_q[k] <= RST_VAL;
                stg_vld_q[k]  <= 1'b0;
            end
            dout_q     <= RST_VAL;
            dout_q_vld <= 1'b0;
            sel_q      <= '0;
            settle_q   <= (SEL_W+1)'(1);
            sel_err_q  <= 1'b0;
        end else begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                stg_data_q[k] <= stg_data_d[k];
                stg_vld_q[k]  <= stg_vld_d[k];
            end
            dout_q     <= dout_d;
            dout_q_vld <= dout_d_vld;
            sel_q      <= sel_d;
            settle_q   <= settle_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign locked  = (settle_q == '0);
    assign sel_err = sel_err_q;

`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
    logic [WIDTH-1:0] neg_data_q, neg_data_d;
    logic             neg_vld_q, neg_vld_d;

    // Half-cycle stage input is the gated posedge output
    always_comb begin
        neg_data_d = dout_q;
        neg_vld_d  = dout_q_vld & locked;
    end

    // Negedge retiming register, cleared when rst is seen high at the falling edge
    always_ff @(negedge clk) begin
        if (rst) begin
            neg_data_q <= RST_VAL;
            neg_vld_q  <= 1'b0;
        end else begin
            neg_data_q <= neg_data_d;
            neg_vld_q  <= neg_vld_d;
        end
    end

    assign dout     = half_sel ? neg_data_q : dout_q;
    assign dout_vld = half_sel ? neg_vld_q  : (dout_q_vld & locked);
`else
    assign dout     = dout_q;
    assign dout_vld = dout_q_vld & locked;
`endif

endmodule

// File: tb/tb_itrx_aib_phy_dly_line.sv
// tb/tb_itrx_aib_phy_dly_line.sv - self-checking bench for itrx_aib_phy_dly_line
module tb_itrx_aib_phy_dly_line;

    localparam int WIDTH     = 8;
    localparam int MAX_DEPTH = 4;
    localparam int SEL_W     = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [SEL_W-1:0] dly_sel;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             locked;
    logic             sel_err;
`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
    logic             half_sel = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    itrx_aib_phy_dly_line dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .din_vld  (din_vld),
        .dly_sel  (dly_sel),
`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
        .half_sel (half_sel),
`endif
        .dout     (dout),
        .dout_vld (dout_vld),
        .locked   (locked),
        .sel_err  (sel_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: history of words offered on enabled cycles, and a count of
    // enabled cycles still to go before the current selection counts as locked.
    logic [WIDTH-1:0] hist_d[$];
    logic             hist_v[$];
    int               m_sel;
    int               m_wait;
    bit               m_err;
    logic [WIDTH-1:0] m_dout;
    bit               m_dvld;
    bit               m_live = 0;
    logic [WIDTH-1:0] m_neg_d = '0;
    bit               m_neg_v = 0;

    always @(posedge clk) begin
        int want;
        if (rst) begin
            hist_d = {};
            hist_v = {};
            for (int i = 0; i <= MAX_DEPTH; i++) begin
                hist_d.push_back('0);
                hist_v.push_back(1'b0);
            end
            m_sel  = 0;
            m_wait = 1;
            m_err  = 0;
            m_dout = '0;
            m_dvld = 0;
            m_live = 1;
        end else if (m_live) begin
            if (int'(dly_sel) > MAX_DEPTH) m_err = 1;
            if (en) begin
                hist_d.push_front(din);
                hist_v.push_front(din_vld);
                m_dout = hist_d[m_sel];
                m_dvld = hist_v[m_sel];
                void'(hist_d.pop_back());
                void'(hist_v.pop_back());
                want = (int'(dly_sel) > MAX_DEPTH) ? MAX_DEPTH : int'(dly_sel);
                if (want != m_sel) begin
                    m_sel  = want;
                    m_wait = want + 1;
                end else if (m_wait > 0) begin
                    m_wait = m_wait - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (rst) begin
                m_neg_d = '0;
                m_neg_v = 0;
            end else begin
                m_neg_d = m_dout;
                m_neg_v = m_dvld && (m_wait == 0);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #3;
        if (m_live) begin
            logic [WIDTH-1:0] e_d;
            bit               e_v;
            e_d = m_dout;
            e_v = m_dvld && (m_wait == 0);
`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
            if (half_sel) begin
                e_d = m_neg_d;
                e_v = m_neg_v;
            end
`endif
            chk("mdl_dout",     32'(dout),     32'(e_d));
            chk("mdl_dout_vld", 32'(dout_vld), 32'(e_v));
            chk("mdl_locked",   32'(locked),   32'(m_wait == 0));
            chk("mdl_sel_err",  32'(sel_err),  32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din = 8'hFF; din_vld = 1'b1; dly_sel = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dout",    32'(dout),     32'h00);
            chk("rst_vld",     32'(dout_vld), 32'h0);
            chk("rst_locked",  32'(locked),   32'h0);
            chk("rst_sel_err", 32'(sel_err),  32'h0);
        end

        // Fixed depth 3, stream 1,2,3,...
        rst = 1'b0; dly_sel = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            din = 8'(i);
            step();
            if (i == 4) chk("d3_not_locked", 32'(locked), 32'h0);
            if (i == 5) begin
                chk("d3_locked", 32'(locked),   32'h1);
                chk("d3_dout",   32'(dout),     32'h02);
                chk("d3_vld",    32'(dout_vld), 32'h1);
            end
            if (i == 8) chk("d3_dout8", 32'(dout), 32'h05);
        end

        // Bypass (depth 0)
        dly_sel = 3'd0; din = 8'h11;
        step();
        chk("byp_change_unlocked", 32'(locked), 32'h0);
        din = 8'h22;
        step();
        chk("byp_relock", 32'(locked), 32'h1);
        din = 8'hA5;
        step();
        chk("byp_dout", 32'(dout),     32'hA5);
        chk("byp_vld",  32'(dout_vld), 32'h1);

        // Lock at depth 2, then change to depth 4
        dly_sel = 3'd2;
        for (int i = 0; i < 4; i++) begin
            din = 8'h30 + 8'(i);
            step();
        end
        chk("d2_locked", 32'(locked), 32'h1);
        dly_sel = 3'd4;
        for (int j = 0; j <= 6; j++) begin
            din = 8'h40 + 8'(j);
            step();
            if (j < 5) begin
                chk("d4_unlocked", 32'(locked),   32'h0);
                chk("d4_vld_gate", 32'(dout_vld), 32'h0);
            end
            if (j == 5) begin
                chk("d4_locked", 32'(locked),   32'h1);
                chk("d4_dout",   32'(dout),     32'h41);
                chk("d4_vld",    32'(dout_vld), 32'h1);
            end
        end
        chk("d4_dout6", 32'(dout), 32'h42);

        // Stall: output frozen while en=0
        en = 1'b0; din = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_dout", 32'(dout), 32'h42);
        end
        en = 1'b1; din = 8'h47;
        step();
        chk("resume_dout", 32'(dout), 32'h43);

        // Out-of-range request: flag updates even with en low, then clamps to 4
        en = 1'b0; dly_sel = 3'd7;
        step();
        chk("oob_err", 32'(sel_err), 32'h1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'h50 + 8'(i);
            step();
            chk("clamp_locked", 32'(locked), 32'h1);
        end
        chk("clamp_dout", 32'(dout), 32'h50);

        // Settle freezes under stall
        dly_sel = 3'd1;
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("settle_frozen", 32'(locked), 32'h0);
        end
        en = 1'b1;
        step();
        chk("settle_one_left", 32'(locked), 32'h0);
        step();
        chk("settle_done",  32'(locked),  32'h1);
        chk("err_sticky",   32'(sel_err), 32'h1);

        // Mid-stream reset discards everything
        rst = 1'b1;
        step();
        chk("mrst_vld",  32'(dout_vld), 32'h0);
        chk("mrst_err",  32'(sel_err),  32'h0);
        chk("mrst_dout", 32'(dout),     32'h00);
        rst = 1'b0;

        // Mixed traffic checked only by the per-cycle model
        for (int i = 0; i < 80; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            din     = 8'($urandom);
            din_vld = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dly_sel = 3'($urandom_range(0, 7));
            rst     = (i == 40);
            step();
        end
        rst = 1'b0;

`ifdef ITRX_AIB_PHY_DLY_NEGEDGE_EN
        rst = 1'b1; en = 1'b1; din_vld = 1'b1; dly_sel = 3'd0;
        step();
        rst = 1'b0; dly_sel = 3'd1; half_sel = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = 8'h60 + 8'(i);
            step();
        end
        @(negedge clk); #1;
        chk("neg_dout", 32'(dout),     32'h62);
        chk("neg_vld",  32'(dout_vld), 32'h1);
        din = 8'h64;
        step();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("neg_rst_dout", 32'(dout),     32'h00);
        chk("neg_rst_vld",  32'(dout_vld), 32'h0);
        step();
        rst = 1'b0; half_sel = 1'b0;
`endif

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
